// File: rtl/matrix_result_buffer_if.sv
// Handshake bundle for the 4x4 matrix result buffer: the write side from the
// multiplier controller plus the ready/valid read stream and status flags.
interface matrix_result_buffer_if #(
    parameter int DW = 16
);
    logic          wr_en;
    logic [3:0]    wr_idx;
    logic [DW-1:0] wr_data;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [3:0]    out_idx;
    logic          out_last;
    logic          busy;
    logic          ovf_err;

    modport master (
        output wr_en, wr_idx, wr_data, out_ready,
        input  out_valid, out_data, out_idx, out_last, busy, ovf_err
    );

    modport slave (
        input  wr_en, wr_idx, wr_data, out_ready,
        output out_valid, out_data, out_idx, out_last, busy, ovf_err
    );
endinterface

// File: rtl/matrix_result_buffer.sv
// Collects 16 result elements in any order, then streams them out idx 0..15
// over a ready/valid handshake; writes that land during the drain are dropped.
module matrix_result_buffer #(
    parameter int DW = 16,
    parameter int N  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    matrix_result_buffer_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    r_state;
    logic [N-1:0]  r_mask;
    logic [3:0]    r_rd_ptr;
    logic          r_ovf;
    logic [DW-1:0] r_mem [N];

    logic [N-1:0]  w_wr_bit;
    logic [N-1:0]  w_mask_nxt;
    logic          w_drain;
    logic          w_wr_ok;
    logic          w_xfer;
    logic          w_rd_last;

    assign w_wr_bit   = {{(N-1){1'b0}}, 1'b1} << bus.wr_idx;
    assign w_mask_nxt = r_mask | w_wr_bit;
    assign w_drain    = (r_state == S_DRAIN);
    assign w_wr_ok    = bus.wr_en && !w_drain;
    assign w_xfer     = w_drain && bus.out_ready;
    assign w_rd_last  = (r_rd_ptr == 4'd15);

    // Storage is not reset; the mask alone decides what counts as written.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_ok)
            r_mem[bus.wr_idx] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mask   <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.wr_en) begin
                        r_mask  <= w_wr_bit;
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (bus.wr_en) begin
                        r_mask <= w_mask_nxt;
                        if (&w_mask_nxt)
                            r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus.wr_en)
                        r_ovf <= 1'b1;
                    if (w_xfer) begin
                        if (w_rd_last) begin
                            r_state  <= S_IDLE;
                            r_mask   <= '0;
                            r_rd_ptr <= '0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_mask   <= '0;
                    r_rd_ptr <= '0;
                end
            endcase
        end
    end

    assign bus.out_valid = w_drain;
    assign bus.out_data  = w_drain ? r_mem[r_rd_ptr] : '0;
    assign bus.out_idx   = w_drain ? r_rd_ptr : 4'd0;
    assign bus.out_last  = w_drain && w_rd_last;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.ovf_err   = r_ovf;
endmodule

// File: doc/matrix_result_buffer.md
MATRIX_RESULT_BUFFER -- requirements
Module: matrix_result_buffer

Interface
REQ-001 Parameter: DW, 16, width of one result element.
REQ-002 Parameter: N, 16, number of result elements per matrix (4x4), fixed at 16.
REQ-003 Port: clk  input  1  single clock, all logic on posedge clk.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: wr_en  input  1  result write strobe, driven by the multiplier controller's done.
REQ-006 Port: wr_idx  input  4  result index 0..15, driven by the multiplier controller's outcount.
REQ-007 Port: wr_data  input  DW  result element for wr_idx.
REQ-008 Port: out_ready  input  1  downstream accepts the current beat.
REQ-009 Port: out_valid  output  1  out_data/out_idx/out_last are valid.
REQ-010 Port: out_data  output  DW  result element being presented.
REQ-011 Port: out_idx  output  4  index of the presented element.
REQ-012 Port: out_last  output  1  high on the beat with out_idx==15.
REQ-013 Port: busy  output  1  high whenever state is not IDLE.
REQ-014 Port: ovf_err  output  1  sticky flag: a write arrived while draining and was dropped.

Function
REQ-015 Storage SHALL be 16 x DW entries plus a 16-bit written-mask, one bit per index.
REQ-016 FSM states SHALL be IDLE (mask all zero), FILL (mask partly set), and DRAIN (presenting results).
REQ-017 In IDLE, wr_en SHALL write mem[wr_idx], set mask[wr_idx], and move to FILL next cycle.
REQ-018 In FILL, wr_en SHALL write mem[wr_idx] and set mask[wr_idx].
REQ-019 A repeated index in FILL SHALL overwrite the data and leave the mask unchanged.
REQ-020 FILL SHALL move to DRAIN on the clock edge that completes the mask (all 16 bits set).
REQ-021 Write order is arbitrary; only mask completeness triggers DRAIN.
REQ-022 Latency: 16th distinct write sampled at edge t -> out_valid=1 with out_idx=0 starting the cycle after edge t.
REQ-023 In DRAIN, out_valid SHALL be 1, out_idx SHALL equal rd_ptr, and out_data SHALL equal mem[rd_ptr].
REQ-024 Handshake: a beat transfers when out_valid && out_ready on a clock edge; rd_ptr then increments by 1.
REQ-025 While out_valid && !out_ready, out_data/out_idx/out_last SHALL hold stable.
REQ-026 The transfer with rd_ptr==15 SHALL return the FSM to IDLE, clear the mask, and set rd_ptr=0; there is no wrap into a second drain.
REQ-027 wr_en in DRAIN, including the cycle of the final transfer, SHALL be dropped (memory and mask unchanged) and SHALL set ovf_err=1.
REQ-028 ovf_err SHALL remain 1 until reset.
REQ-029 Outside DRAIN, out_valid=0, out_data=0, out_idx=0, and out_last=0.
REQ-030 out_last SHALL be 1 only when out_valid=1 and out_idx==15.
REQ-031 Full throughput: with out_ready held at 1, DRAIN lasts exactly 16 cycles, then IDLE.
REQ-032 The earliest IDLE write after DRAIN is accepted in the first IDLE cycle.

Reset
REQ-033 reset=1 at an edge SHALL force IDLE, mask=0, rd_ptr=0, and ovf_err=0.
REQ-034 After reset, all outputs SHALL read 0 (busy=0) in the following cycle.
REQ-035 Reset SHALL take priority over any simultaneous wr_en or handshake; memory contents need not be cleared.
REQ-036 Reset mid-FILL or mid-DRAIN SHALL discard the partial matrix; the next matrix needs all 16 writes.

Verification
REQ-037 In-order fill: write idx 0..15 with data 0x100+i on consecutive cycles, out_ready=1 -> 16 beats idx 0..15 with data 0x100..0x10F, out_last on 0x10F, busy low 16 cycles after the first beat.
REQ-038 Backpressure: fill as REQ-037, then out_ready toggling 1,0,0,1,... -> each beat is held stable while out_ready=0, no beat is lost or duplicated, and order is idx 0..15.
REQ-039 Scrambled/duplicate fill: write idx 15..0 descending, with idx 3 written twice (0xAAAA then 0x0003) before the set completes -> DRAIN starts only after the 16th distinct index, and beat 3 carries 0x0003.
REQ-040 Overflow: wr_en=1 (idx 5, 0xFFFF) during beat 2 of DRAIN -> ovf_err=1 and stays 1, and beat 5 still carries its original data.
REQ-041 Reset mid-drain: assert reset after beat 7 -> next cycle out_valid=0, busy=0, ovf_err=0; a fresh 16-write fill then drains from idx 0.
REQ-042 Back-to-back: the second matrix's first write arrives the cycle after the final transfer -> it is accepted (not dropped), ovf_err stays 0, and the second drain is correct.
